// File: rtl/bids22_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bids22_ctrl_sequencer
// Purpose  : Controller-side master that configures, locks and starts a bids22
//            round, then reports maxBid or the failing step and error code.
// Revision : 1.0 - initial release
// ============================================================================
module bids22_ctrl_sequencer #(
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_go,
  input  logic [DATAWIDTH-1:0] cfg_key,
  input  logic [DATAWIDTH-1:0] cfg_xval,
  input  logic [DATAWIDTH-1:0] cfg_yval,
  input  logic [DATAWIDTH-1:0] cfg_zval,
  input  logic [2:0]           cfg_mask,
  input  logic [DATAWIDTH-1:0] cfg_timer,
  input  logic [DATAWIDTH-1:0] cfg_bidcharge,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [2:0]           fail_err,
  output logic                 fail_timeout,
  output logic [3:0]           fail_step,
  output logic [DATAWIDTH-1:0] result_maxbid,
  output logic [DATAWIDTH-1:0] C_data,
  output logic [3:0]           C_op,
  output logic                 C_start,
  input  logic                 ready,
  input  logic [2:0]           err,
  input  logic                 roundOver,
  input  logic [DATAWIDTH-1:0] maxBid
);

  localparam logic [3:0] c_OP_NO_OP        = 4'd0;
  localparam logic [3:0] c_OP_UNLOCK       = 4'd1;
  localparam logic [3:0] c_OP_LOADX        = 4'd2;
  localparam logic [3:0] c_OP_LOADY        = 4'd3;
  localparam logic [3:0] c_OP_LOADZ        = 4'd4;
  localparam logic [3:0] c_OP_SETMASK      = 4'd5;
  localparam logic [3:0] c_OP_SETTIMER     = 4'd6;
  localparam logic [3:0] c_OP_SETBIDCHARGE = 4'd7;
  localparam logic [3:0] c_OP_LOCK         = 4'd8;
  localparam logic [2:0] c_NOERROR         = 3'd0;

  localparam int             TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  c_TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_SWAIT = 3'd4,
    S_RUN   = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t               r_state;
  logic [3:0]           r_step;
  logic [TW-1:0]        r_tmo;
  logic [DATAWIDTH-1:0] r_key, r_x, r_y, r_z, r_timer, r_charge;
  logic [2:0]           r_mask;
  logic                 r_busy, r_done, r_fail, r_fail_timeout, r_start;
  logic [2:0]           r_fail_err;
  logic [3:0]           r_fail_step, r_op;
  logic [DATAWIDTH-1:0] r_maxbid, r_data;

  logic [3:0]           w_cur_op;
  logic [DATAWIDTH-1:0] w_cur_data;
  logic                 w_tmo_hit;

  // Step 8 is the C_start step, which reports as NO_OP on failure.
  always_comb begin
    w_cur_op   = c_OP_NO_OP;
    w_cur_data = '0;
    case (r_step)
      4'd0: begin w_cur_op = c_OP_UNLOCK;       w_cur_data = r_key;    end
      4'd1: begin w_cur_op = c_OP_LOADX;        w_cur_data = r_x;      end
      4'd2: begin w_cur_op = c_OP_LOADY;        w_cur_data = r_y;      end
      4'd3: begin w_cur_op = c_OP_LOADZ;        w_cur_data = r_z;      end
      4'd4: begin w_cur_op = c_OP_SETMASK;      w_cur_data = DATAWIDTH'(r_mask); end
      4'd5: begin w_cur_op = c_OP_SETTIMER;     w_cur_data = r_timer;  end
      4'd6: begin w_cur_op = c_OP_SETBIDCHARGE; w_cur_data = r_charge; end
      4'd7: begin w_cur_op = c_OP_LOCK;         w_cur_data = r_key;    end
      default: begin w_cur_op = c_OP_NO_OP;     w_cur_data = '0;       end
    endcase
  end

  assign w_tmo_hit = (r_tmo == c_TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_step         <= 4'd0;
      r_tmo          <= '0;
      r_key          <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_z            <= '0;
      r_timer        <= '0;
      r_charge       <= '0;
      r_mask         <= 3'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fail         <= 1'b0;
      r_fail_timeout <= 1'b0;
      r_fail_err     <= c_NOERROR;
      r_fail_step    <= c_OP_NO_OP;
      r_maxbid       <= '0;
      r_op           <= c_OP_NO_OP;
      r_data         <= '0;
      r_start        <= 1'b0;
    end else begin
      r_op    <= c_OP_NO_OP;
      r_data  <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_go) begin
            r_key          <= cfg_key;
            r_x            <= cfg_xval;
            r_y            <= cfg_yval;
            r_z            <= cfg_zval;
            r_mask         <= cfg_mask;
            r_timer        <= cfg_timer;
            r_charge       <= cfg_bidcharge;
            r_busy         <= 1'b1;
            r_step         <= 4'd0;
            r_tmo          <= '0;
            r_fail_err     <= c_NOERROR;
            r_fail_step    <= c_OP_NO_OP;
            r_fail_timeout <= 1'b0;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT, S_START, S_SWAIT: begin
          if (ready) begin
            r_tmo <= '0;
            if (r_state == S_ISSUE) begin
              r_op    <= w_cur_op;
              r_data  <= w_cur_data;
              r_state <= S_WAIT;
            end else if (r_state == S_START) begin
              r_start <= 1'b1;
              r_state <= S_SWAIT;
            end else if (err != c_NOERROR) begin
              r_fail      <= 1'b1;
              r_fail_err  <= err;
              r_fail_step <= w_cur_op;
              r_state     <= S_FIN;
            end else if (r_state == S_SWAIT) begin
              r_state <= S_RUN;
            end else begin
              r_step  <= r_step + 4'd1;
              r_state <= (r_step == 4'd7) ? S_START : S_ISSUE;
            end
          end else if (w_tmo_hit) begin
            r_fail         <= 1'b1;
            r_fail_timeout <= 1'b1;
            r_fail_err     <= c_NOERROR;
            r_fail_step    <= w_cur_op;
            r_state        <= S_FIN;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_RUN: begin
          if (roundOver) begin
            r_maxbid <= maxBid;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end
        end
        // The done/fail pulse cycle; busy drops after it.
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign fail          = r_fail;
  assign fail_err      = r_fail_err;
  assign fail_timeout  = r_fail_timeout;
  assign fail_step     = r_fail_step;
  assign result_maxbid = r_maxbid;
  assign C_data        = r_data;
  assign C_op          = r_op;
  assign C_start       = r_start;

endmodule
`default_nettype wire
